stream_demux: RTL and testbench

Packet-aware AXI4-Stream 1-to-M_COUNT demultiplexer for the stream-switch DFX plugin. It consumes the committed output-select value from the demux control register block and routes each packet to exactly one master port. The select value is sampled only on the first beat of a packet, so mid-packet select changes never split a packet. Packets whose select is out of range are dropped and counted.

---
 rtl/stream_demux_pkg.sv | 14 +
 rtl/stream_demux_if.sv | 39 +++
 rtl/stream_demux_skid.sv | 57 +++++
 rtl/stream_demux.sv | 115 +++++++++++
 tb/tb_stream_demux.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/stream_demux_pkg.sv
// Shared definitions for the packet-aware stream demultiplexer.
package stream_demux_pkg;

  // Width of the dropped-packet counter.
  localparam int DROP_CNT_W = 32;

  typedef logic [DROP_CNT_W-1:0] drop_cnt_t;

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic drop_cnt_t sat_inc(input drop_cnt_t value);
    return (&value) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/stream_demux_if.sv
// AXI4-Stream bundle for the demux: one slave stream in, M_COUNT broadcast
// master streams out. The slave modport is the demux's view; the master
// modport is the view of whatever drives and sinks it.
interface stream_demux_if #(
  parameter int DATA_W  = 512,
  parameter int KEEP_W  = DATA_W / 8,
  parameter int USER_W  = 48,
  parameter int M_COUNT = 2
);

  logic                        s_axis_tvalid;
  logic                        s_axis_tready;
  logic [DATA_W-1:0]           s_axis_tdata;
  logic [KEEP_W-1:0]           s_axis_tkeep;
  logic [USER_W-1:0]           s_axis_tuser;
  logic                        s_axis_tlast;

  logic [M_COUNT-1:0]          m_axis_tvalid;
  logic [M_COUNT-1:0]          m_axis_tready;
  logic [M_COUNT*DATA_W-1:0]   m_axis_tdata;
  logic [M_COUNT*KEEP_W-1:0]   m_axis_tkeep;
  logic [M_COUNT*USER_W-1:0]   m_axis_tuser;
  logic [M_COUNT-1:0]          m_axis_tlast;

  modport slave (
    input  s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast,
    output s_axis_tready,
    output m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast,
    input  m_axis_tready
  );

  modport master (
    output s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast,
    input  s_axis_tready,
    input  m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast,
    output m_axis_tready
  );

endinterface

// File: rtl/stream_demux_skid.sv
// Two-entry register slice (output register plus skid register) carrying an
// arbitrary packed beat type. in_ready is a register output, so upstream never
// sees a combinational path from out_ready.
module stream_demux_skid
  import stream_demux_pkg::*;
#(
  parameter type T = logic
) (
  input  logic axis_aclk,
  input  logic axis_rst,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);

  T     out_reg;
  T     skid_reg;
  logic out_valid_reg;
  logic skid_valid_reg;
  logic take;
  logic load_out;

  // A beat enters whenever the skid slot is free; the output register may
  // load whenever it is empty or its consumer is taking the current beat.
  assign take     = in_valid && !skid_valid_reg;
  assign load_out = !out_valid_reg || out_ready;

  assign in_ready  = !skid_valid_reg;
  assign out_valid = out_valid_reg;
  assign out_data  = out_reg;

  // Occupancy flags: skid drains first, so accept order is preserved.
  always_ff @(posedge axis_aclk) begin
    if (axis_rst) begin
      out_valid_reg  <= 1'b0;
      skid_valid_reg <= 1'b0;
    end else if (load_out) begin
      out_valid_reg  <= skid_valid_reg || take;
      skid_valid_reg <= 1'b0;
    end else if (take) begin
      skid_valid_reg <= 1'b1;
    end
  end

  // Payload registers carry no reset; they only matter while flagged valid.
  always_ff @(posedge axis_aclk) begin
    if (load_out) begin
      out_reg <= skid_valid_reg ? skid_reg : in_data;
    end else if (take) begin
      skid_reg <= in_data;
    end
  end

endmodule

// File: rtl/stream_demux.sv
// Packet-aware 1-to-M_COUNT AXI4-Stream demultiplexer. The route is latched
// on the first beat of each packet, out-of-range routes are discarded and
// counted, and forwarded beats pass through a two-entry register slice whose
// output is broadcast to all ports with a one-hot tvalid.
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int DATA_W     = 512,
  parameter int KEEP_W     = DATA_W / 8,
  parameter int USER_W     = 48,
  parameter int M_COUNT    = 2,
  parameter int CL_M_COUNT = $clog2(M_COUNT)
) (
  input  logic                  axis_aclk,
  input  logic                  axis_rst,
  input  logic [CL_M_COUNT-1:0] select,
  stream_demux_if.slave         axis,
  output logic [DROP_CNT_W-1:0] drop_count,
  output logic                  in_packet
);

  typedef struct packed {
    logic [DATA_W-1:0]     tdata;
    logic [KEEP_W-1:0]     tkeep;
    logic                  tlast;
    logic [USER_W-1:0]     tuser;
    logic [CL_M_COUNT-1:0] route;
  } beat_t;

  // Select values at or above this limit address no port.
  localparam logic [CL_M_COUNT:0] M_COUNT_LIM = M_COUNT[CL_M_COUNT:0];

  logic                  in_packet_reg;
  logic [CL_M_COUNT-1:0] route_reg;
  logic                  drop_reg;
  drop_cnt_t             drop_count_reg;

  logic [CL_M_COUNT-1:0] cur_route;
  logic                  cur_drop;
  logic                  s_ready;
  logic                  accept;
  logic                  buf_in_valid;
  beat_t                 in_beat;
  beat_t                 out_beat;
  logic                  out_valid;
  logic                  out_ready;
  logic [M_COUNT-1:0]    port_hit;

  // First beat uses the live select; later beats reuse the held decision.
  assign cur_route = in_packet_reg ? route_reg : select;
  assign cur_drop  = in_packet_reg ? drop_reg : ({1'b0, select} >= M_COUNT_LIM);

  assign accept       = axis.s_axis_tvalid && s_ready;
  assign buf_in_valid = axis.s_axis_tvalid && !cur_drop;

  // Dropped beats still see the same ready, so upstream timing is unchanged.
  assign axis.s_axis_tready = s_ready;
  assign drop_count         = drop_count_reg;
  assign in_packet          = in_packet_reg;

  // Pack the incoming beat together with its resolved route.
  always_comb begin
    in_beat       = '0;
    in_beat.tdata = axis.s_axis_tdata;
    in_beat.tkeep = axis.s_axis_tkeep;
    in_beat.tlast = axis.s_axis_tlast;
    in_beat.tuser = axis.s_axis_tuser;
    in_beat.route = cur_route;
  end

  // Packet framing, route capture and saturating drop counter.
  always_ff @(posedge axis_aclk) begin
    if (axis_rst) begin
      in_packet_reg  <= 1'b0;
      route_reg      <= '0;
      drop_reg       <= 1'b0;
      drop_count_reg <= '0;
    end else if (accept) begin
      if (!in_packet_reg) begin
        route_reg <= select;
        drop_reg  <= cur_drop;
      end
      in_packet_reg <= !axis.s_axis_tlast;
      if (cur_drop && axis.s_axis_tlast) begin
        drop_count_reg <= sat_inc(drop_count_reg);
      end
    end
  end

  stream_demux_skid #(
    .T (beat_t)
  ) u_skid (
    .axis_aclk (axis_aclk),
    .axis_rst  (axis_rst),
    .in_valid  (buf_in_valid),
    .in_ready  (s_ready),
    .in_data   (in_beat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_beat)
  );

  // The head beat only advances on the ready of the port it is routed to.
  assign out_ready = |(port_hit & axis.m_axis_tready);

  for (genvar gi = 0; gi < M_COUNT; gi++) begin : g_port
    assign port_hit[gi]                          = (out_beat.route == CL_M_COUNT'(gi));
    assign axis.m_axis_tvalid[gi]                = out_valid && port_hit[gi];
    assign axis.m_axis_tlast[gi]                 = out_beat.tlast;
    assign axis.m_axis_tdata[gi*DATA_W +: DATA_W] = out_beat.tdata;
    assign axis.m_axis_tkeep[gi*KEEP_W +: KEEP_W] = out_beat.tkeep;
    assign axis.m_axis_tuser[gi*USER_W +: USER_W] = out_beat.tuser;
  end

endmodule

// File: tb/tb_stream_demux.sv
// Bench for stream_demux with three ports and 64-bit data. A queue of
// expected beats in accept order stands in for the buffer; buffer-full is
// two queued beats.
module tb_stream_demux;
  localparam int DW = 64;
  localparam int KW = 8;
  localparam int UW = 8;
  localparam int MC = 3;
  localparam int CL = 2;

  typedef struct {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic [UW-1:0] u;
    logic          l;
    int            port;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [CL-1:0] sel;
  logic [31:0]   dcnt;
  logic          inpkt;

  stream_demux_if #(.DATA_W(DW), .KEEP_W(KW), .USER_W(UW), .M_COUNT(MC)) bus ();

  stream_demux #(
    .DATA_W(DW), .KEEP_W(KW), .USER_W(UW), .M_COUNT(MC), .CL_M_COUNT(CL)
  ) dut (
    .axis_aclk  (clk),
    .axis_rst   (rst),
    .select     (sel),
    .axis       (bus),
    .drop_count (dcnt),
    .in_packet  (inpkt)
  );

  always #5 clk = ~clk;

  ent_t        q[$];
  bit          m_inpkt;
  int          m_route;
  bit          m_drop;
  logic [31:0] m_dcnt;
  bit          accepted;
  int          obs_cnt[MC];
  int          n_cmp = 0;
  int          n_err = 0;
  bit          rand_ready = 0;
  int          stall_port = 0;
  int          stall_left = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_inpkt = 0;
    m_route = 0;
    m_drop  = 0;
    m_dcnt  = '0;
  endtask

  task automatic clear_obs();
    for (int p = 0; p < MC; p++) obs_cnt[p] = 0;
  endtask

  // One clock: apply ready pattern, compare outputs with the model, then
  // advance the model by the handshakes that happen at the coming edge.
  task automatic cycle();
    logic        exp_rdy;
    logic [2:0]  exp_valid;
    bit          acc;
    bit          pop;
    ent_t        e;
    if (rand_ready) bus.m_axis_tready = 3'($urandom);
    else            bus.m_axis_tready = 3'b111;
    if (stall_left > 0) begin
      bus.m_axis_tready[stall_port] = 1'b0;
      stall_left--;
    end
    exp_rdy   = (q.size() < 2);
    exp_valid = (q.size() > 0) ? (3'b001 << q[0].port) : 3'b000;
    check("s_tready", 64'(bus.s_axis_tready), 64'(exp_rdy));
    check("m_tvalid", 64'(bus.m_axis_tvalid), 64'(exp_valid));
    check("in_packet", 64'(inpkt), 64'(m_inpkt));
    check("drop_count", 64'(dcnt), 64'(m_dcnt));
    if (q.size() > 0) begin
      for (int p = 0; p < MC; p++)
        check($sformatf("tdata_p%0d", p), bus.m_axis_tdata[p*DW +: DW], q[0].d);
      check("tkeep", 64'(bus.m_axis_tkeep[q[0].port*KW +: KW]), 64'(q[0].k));
      check("tuser", 64'(bus.m_axis_tuser[q[0].port*UW +: UW]), 64'(q[0].u));
      check("tlast", 64'(bus.m_axis_tlast[q[0].port]), 64'(q[0].l));
    end
    for (int p = 0; p < MC; p++)
      if (bus.m_axis_tvalid[p] && bus.m_axis_tready[p]) obs_cnt[p]++;
    acc = bus.s_axis_tvalid && exp_rdy;
    pop = (q.size() > 0) && bus.m_axis_tready[q[0].port];
    if (pop) void'(q.pop_front());
    if (acc) begin
      if (!m_inpkt) begin
        m_route = int'(sel);
        m_drop  = (int'(sel) >= MC);
      end
      if (m_drop) begin
        if (bus.s_axis_tlast && m_dcnt != 32'hFFFF_FFFF) m_dcnt = m_dcnt + 1;
      end else begin
        e.d = bus.s_axis_tdata; e.k = bus.s_axis_tkeep; e.u = bus.s_axis_tuser;
        e.l = bus.s_axis_tlast; e.port = m_route;
        q.push_back(e);
      end
      m_inpkt = !bus.s_axis_tlast;
    end
    accepted = acc;
    @(posedge clk);
    #1;
  endtask

  // Present one random beat and hold it until it is accepted.
  task automatic send_beat(input bit last);
    int budget = 0;
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tdata  = {$urandom, $urandom};
    bus.s_axis_tkeep  = KW'($urandom);
    bus.s_axis_tuser  = UW'($urandom);
    bus.s_axis_tlast  = last;
    accepted = 0;
    while (!accepted) begin
      cycle();
      budget++;
      if (!accepted && budget > 200) begin
        n_cmp++; n_err++;
        $error("FAIL accept_timeout: observed=no_accept expected=accept");
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    bus.s_axis_tvalid = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic drain();
    int budget = 0;
    bus.s_axis_tvalid = 1'b0;
    while (q.size() > 0) begin
      cycle();
      budget++;
      if (budget > 300) begin
        n_cmp++; n_err++;
        $error("FAIL drain_timeout: observed=%0d_left expected=0", q.size());
        break;
      end
    end
    cycle();
  endtask

  initial begin
    rst = 1'b1;
    sel = '0;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tdata  = '0;
    bus.s_axis_tkeep  = '0;
    bus.s_axis_tuser  = '0;
    bus.s_axis_tlast  = 1'b0;
    bus.m_axis_tready = 3'b111;
    model_reset();
    clear_obs();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    // Four-beat packet to port 1, all readies high.
    sel = 2'd1; clear_obs();
    for (int b = 0; b < 4; b++) send_beat(b == 3);
    drain();
    check("s1_port1_beats", 64'(obs_cnt[1]), 64'd4);
    check("s1_other_beats", 64'(obs_cnt[0] + obs_cnt[2]), 64'd0);

    // Select changes after the first beat; the packet stays on port 0.
    sel = 2'd0; clear_obs();
    send_beat(0);
    sel = 2'd2;
    send_beat(0);
    send_beat(1);
    send_beat(0);
    send_beat(1);
    drain();
    check("s2_port0_beats", 64'(obs_cnt[0]), 64'd3);
    check("s2_port2_beats", 64'(obs_cnt[2]), 64'd2);

    // Out-of-range select: two 2-beat packets dropped and counted.
    sel = 2'd3; clear_obs();
    for (int p = 0; p < 2; p++) begin
      send_beat(0);
      send_beat(1);
    end
    drain();
    check("s3_drop_count", 64'(dcnt), 64'd2);
    check("s3_no_output", 64'(obs_cnt[0] + obs_cnt[1] + obs_cnt[2]), 64'd0);

    // Port 1 stalls for five cycles during a continuous six-beat stream.
    sel = 2'd1; clear_obs();
    send_beat(0);
    stall_port = 1; stall_left = 5;
    for (int b = 1; b < 6; b++) send_beat(b == 5);
    drain();
    check("s4_port1_beats", 64'(obs_cnt[1]), 64'd6);

    // Back-to-back single-beat packets alternating between ports 0 and 1.
    clear_obs();
    for (int i = 0; i < 4; i++) begin
      sel = CL'(i % 2);
      send_beat(1);
    end
    drain();
    check("s5_port0_beats", 64'(obs_cnt[0]), 64'd2);
    check("s5_port1_beats", 64'(obs_cnt[1]), 64'd2);

    // Reset mid-packet with two beats buffered behind a stalled port 2.
    sel = 2'd2; clear_obs();
    stall_port = 2; stall_left = 50;
    send_beat(0);
    send_beat(0);
    bus.s_axis_tvalid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    stall_left = 0;
    clear_obs();
    sel = 2'd0;
    send_beat(1);
    drain();
    check("s6_port0_beats", 64'(obs_cnt[0]), 64'd1);
    check("s6_port2_beats", 64'(obs_cnt[2]), 64'd0);

    // Random packets, random selects (including out of range), random
    // readies, gaps and mid-packet select changes.
    rand_ready = 1;
    for (int p = 0; p < 40; p++) begin
      int len;
      sel = CL'($urandom_range(0, 3));
      len = $urandom_range(1, 4);
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 3) == 0) idle(1);
        send_beat(b == len - 1);
        sel = CL'($urandom_range(0, 3));
      end
    end
    drain();
    rand_ready = 0;
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
